// File: rtl/text_glyph_serializer.sv
// Text-mode front end: tracks the character cell under the raster, fetches char/attr and glyph
// rows, and serialises glyph bits with blink and cursor applied. Fixed 3-clock latency.
module text_glyph_serializer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 25,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned CUR_START    = 14,
  parameter int unsigned CUR_END      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blink_en,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [10:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel,
  output logic [7:0]  attribute,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [6:0] ColMax   = 7'(COLS - 1);
  localparam logic [4:0] RowMax   = 5'(ROWS - 1);
  localparam logic [3:0] LineMax  = 4'(CHAR_H - 1);
  localparam logic [3:0] CurStart = 4'(CUR_START);
  localparam logic [3:0] CurEnd   = 4'(CUR_END);
  localparam int unsigned FrameW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FrameW-1:0] FrameMax = FrameW'(BLINK_FRAMES - 1);

  // Raster position
  logic [2:0]  px_q, px_d;
  logic [6:0]  col_q, col_d;
  logic [3:0]  line_q, line_d;
  logic [4:0]  row_q, row_d;
  logic        de_prev_q;
  logic        vs_prev_q;

  // Blink timing
  logic [FrameW-1:0] frame_q, frame_d;
  logic              blink_phase_q, blink_phase_d;

  // Fetch pipeline
  logic        fetch;
  logic        cur_match;
  logic [10:0] text_addr_q, text_addr_d;
  logic        fetch1_q;
  logic [3:0]  line1_q, line1_d;
  logic        cur1_q, cur1_d;
  logic        fetch2_q;
  logic [11:0] font_addr_q, font_addr_d;
  logic [7:0]  attr2_q, attr2_d;
  logic        cur2_q, cur2_d;

  // Serialiser stage
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  attr_q, attr_d;
  logic        cur_hit_q, cur_hit_d;

  // Sync delay lines
  logic [2:0]  de_dly_q;
  logic [2:0]  hs_dly_q;
  logic [2:0]  vs_dly_q;

  logic        blink_off;
  logic        cursor_on;

  always_comb begin
    fetch     = de_in && (px_q == 3'd0);
    cur_match = cursor_en && (col_q == cursor_col) && (row_q == cursor_row) &&
                (line_q >= CurStart) && (line_q <= CurEnd);

    // px/col only advance inside active video; they restart at 0 on every line.
    px_d  = '0;
    col_d = '0;
    if (de_in) begin
      px_d  = px_q + 3'd1;
      col_d = col_q;
      if ((px_q == 3'd7) && (col_q != ColMax)) begin
        col_d = col_q + 7'd1;
      end
    end

    line_d = line_q;
    row_d  = row_q;
    if (vsync_in) begin
      line_d = '0;
      row_d  = '0;
    end else if (de_prev_q && !de_in) begin
      if (line_q == LineMax) begin
        line_d = '0;
        if (row_q != RowMax) begin
          row_d = row_q + 5'd1;
        end
      end else begin
        line_d = line_q + 4'd1;
      end
    end

    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    if (vsync_in && !vs_prev_q) begin
      if (frame_q == FrameMax) begin
        frame_d       = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // Stage 1: text RAM address for the cell starting now
    text_addr_d = text_addr_q;
    line1_d     = line1_q;
    cur1_d      = cur1_q;
    if (fetch) begin
      text_addr_d = 11'(32'(row_q) * COLS + 32'(col_q));
      line1_d     = line_q;
      cur1_d      = cur_match;
    end

    // Stage 2: text data back, issue font fetch
    font_addr_d = font_addr_q;
    attr2_d     = attr2_q;
    cur2_d      = cur2_q;
    if (fetch1_q) begin
      font_addr_d = {text_data[7:0], line1_q};
      attr2_d     = text_data[15:8];
      cur2_d      = cur1_q;
    end

    // Stage 3: the load lands exactly as the previous cell's last bit leaves
    shift_d   = {shift_q[6:0], 1'b0};
    attr_d    = attr_q;
    cur_hit_d = cur_hit_q;
    if (fetch2_q) begin
      shift_d   = font_data;
      attr_d    = attr2_q;
      cur_hit_d = cur2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q          <= '0;
      col_q         <= '0;
      line_q        <= '0;
      row_q         <= '0;
      de_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      text_addr_q   <= '0;
      fetch1_q      <= 1'b0;
      line1_q       <= '0;
      cur1_q        <= 1'b0;
      fetch2_q      <= 1'b0;
      font_addr_q   <= '0;
      attr2_q       <= '0;
      cur2_q        <= 1'b0;
      shift_q       <= '0;
      attr_q        <= '0;
      cur_hit_q     <= 1'b0;
      de_dly_q      <= '0;
      hs_dly_q      <= '0;
      vs_dly_q      <= '0;
    end else begin
      px_q          <= px_d;
      col_q         <= col_d;
      line_q        <= line_d;
      row_q         <= row_d;
      de_prev_q     <= de_in;
      vs_prev_q     <= vsync_in;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      text_addr_q   <= text_addr_d;
      fetch1_q      <= fetch;
      line1_q       <= line1_d;
      cur1_q        <= cur1_d;
      fetch2_q      <= fetch1_q;
      font_addr_q   <= font_addr_d;
      attr2_q       <= attr2_d;
      cur2_q        <= cur2_d;
      shift_q       <= shift_d;
      attr_q        <= attr_d;
      cur_hit_q     <= cur_hit_d;
      de_dly_q      <= {de_dly_q[1:0], de_in};
      hs_dly_q      <= {hs_dly_q[1:0], hsync_in};
      vs_dly_q      <= {vs_dly_q[1:0], vsync_in};
    end
  end

  // Cursor wins over blink suppression; both gated by the delayed display enable.
  assign blink_off = blink_en && attr_q[7] && !blink_phase_q;
  assign cursor_on = cur_hit_q && blink_phase_q;

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign pixel     = de_dly_q[2] && (cursor_on || (shift_q[7] && !blink_off));
  assign attribute = blink_en ? {1'b0, attr_q[6:0]} : attr_q;
  assign de_out    = de_dly_q[2];
  assign hsync_out = hs_dly_q[2];
  assign vsync_out = vs_dly_q[2];

endmodule

// File: tb/tb_text_glyph_serializer.sv
// Directed bench for text_glyph_serializer: behavioural text RAM and font ROM models with
// per-scenario tasks checking pixel timing, addressing, blink and cursor.
module tb_text_glyph_serializer;

  logic        clk;
  logic        rst_n;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        blink_en;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [10:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        pixel;
  logic [7:0]  attribute;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;

  logic [15:0] tmem [2048];
  logic [7:0]  fmem [4096];

  int checks = 0;
  int passes = 0;

  // Memories return data in the cycle after the address register updates
  assign text_data = tmem[text_addr];
  assign font_data = fmem[font_addr];

  text_glyph_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_in      (de_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blink_en   (blink_en),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .text_addr  (text_addr),
    .text_data  (text_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .pixel      (pixel),
    .attribute  (attribute),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    de_in     = 1'b0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    blink_en  = 1'b0;
    cursor_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic skip_lines(input int n);
    for (int i = 0; i < n; i++) begin
      de_in = 1'b1;
      tick();
      de_in = 1'b0;
      tick();
    end
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({text_addr, font_addr} !== 23'd0)
      $display("FAIL reset_addr got %h/%h want 0/0", text_addr, font_addr);
    else passes++;
    checks++;
    if ({pixel, attribute, de_out, hsync_out, vsync_out} !== 12'd0)
      $display("FAIL reset_out got %b want 0", {pixel, attribute, de_out, hsync_out, vsync_out});
    else passes++;
    tick();

    tmem[0] = {8'h1F, 8'h41};
    fmem[12'h410] = 8'hA5;
    de_in    = 1'b1;
    hsync_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 5) tick();
    end
    // Async reset mid-line, away from any clock edge
    #2;
    rst_n    = 1'b0;
    de_in    = 1'b0;
    hsync_in = 1'b0;
    #1;
    checks++;
    if ({pixel, attribute, de_out, hsync_out, vsync_out} !== 12'd0)
      $display("FAIL reset_midline_out got %b want 0",
               {pixel, attribute, de_out, hsync_out, vsync_out});
    else passes++;
    checks++;
    if ({text_addr, font_addr} !== 23'd0)
      $display("FAIL reset_midline_addr got %h/%h want 0/0", text_addr, font_addr);
    else passes++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    de_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) de_in = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if ({de_out, pixel} !== 2'b00)
          $display("FAIL reset_resume_c2 got %b want 00", {de_out, pixel});
        else passes++;
      end
      if (c == 3) begin
        checks++;
        if ({de_out, pixel} !== 2'b11)
          $display("FAIL reset_resume_c3 got %b want 11", {de_out, pixel});
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_cell_pixels();
    logic [7:0] g;
    logic       exp;
    do_reset();
    tmem[0] = {8'h1F, 8'h41};
    tmem[1] = 16'h0000;
    fmem[12'h410] = 8'hA5;
    g = 8'hA5;
    de_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 16) de_in = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (text_addr !== 11'd0) $display("FAIL cell_text_addr got %0d want 0", text_addr);
        else passes++;
      end
      if (c == 2) begin
        checks++;
        if (font_addr !== 12'h410) $display("FAIL cell_font_addr got %h want 410", font_addr);
        else passes++;
      end
      if (c >= 3 && c <= 10) begin
        exp = g[3'(10 - c)];
        checks++;
        if (pixel !== exp) $display("FAIL cell_pixel c=%0d got %b want %b", c, pixel, exp);
        else passes++;
        checks++;
        if (attribute !== 8'h1F)
          $display("FAIL cell_attr c=%0d got %h want 1f", c, attribute);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_addressing();
    do_reset();
    tmem[85]   = {8'h07, 8'h5A};
    fmem[12'h5A1] = 8'h3C;
    tmem[1920] = {8'h0F, 8'h77};
    vsync_pulse();
    skip_lines(17);
    de_in = 1'b1;
    for (int c = 0; c < 662; c++) begin
      if (c == 656) de_in = 1'b0;
      @(negedge clk);
      if (c == 41) begin
        checks++;
        if (text_addr !== 11'd85) $display("FAIL addr_text got %0d want 85", text_addr);
        else passes++;
      end
      if (c == 42) begin
        checks++;
        if (font_addr !== 12'h5A1) $display("FAIL addr_font got %h want 5a1", font_addr);
        else passes++;
      end
      if (c == 43 || c == 45) begin
        checks++;
        if (pixel !== (c == 45)) $display("FAIL addr_pixel c=%0d got %b want %b", c, pixel, c == 45);
        else passes++;
      end
      if (c == 641 || c == 649) begin
        checks++;
        if (text_addr !== 11'd159)
          $display("FAIL addr_col_sat c=%0d got %0d want 159", c, text_addr);
        else passes++;
      end
      tick();
    end

    vsync_pulse();
    skip_lines(480);
    de_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) de_in = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (text_addr !== 11'd1920) $display("FAIL addr_row_sat got %0d want 1920", text_addr);
        else passes++;
      end
      if (c == 2) begin
        checks++;
        if (font_addr !== 12'h770) $display("FAIL addr_row_font got %h want 770", font_addr);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic de_v [32];
    logic hs_v [32];
    logic vs_v [32];
    logic exp;
    do_reset();
    tmem[0] = {8'h1F, 8'h10};
    tmem[1] = {8'h1F, 8'h11};
    fmem[12'h100] = 8'hFF;
    fmem[12'h110] = 8'h00;
    for (int c = 0; c < 32; c++) begin
      de_v[c] = (c < 16);
      hs_v[c] = (c >= 18 && c < 22);
      vs_v[c] = (c >= 24 && c < 26);
    end
    for (int c = 0; c < 32; c++) begin
      de_in    = de_v[c];
      hsync_in = hs_v[c];
      vsync_in = vs_v[c];
      @(negedge clk);
      exp = (c >= 3) ? de_v[c-3] : 1'b0;
      checks++;
      if (de_out !== exp) $display("FAIL b2b_de c=%0d got %b want %b", c, de_out, exp);
      else passes++;
      exp = (c >= 3) ? hs_v[c-3] : 1'b0;
      checks++;
      if (hsync_out !== exp) $display("FAIL b2b_hs c=%0d got %b want %b", c, hsync_out, exp);
      else passes++;
      exp = (c >= 3) ? vs_v[c-3] : 1'b0;
      checks++;
      if (vsync_out !== exp) $display("FAIL b2b_vs c=%0d got %b want %b", c, vsync_out, exp);
      else passes++;
      if (c >= 3 && c <= 19) begin
        exp = (c <= 10);
        checks++;
        if (pixel !== exp) $display("FAIL b2b_pixel c=%0d got %b want %b", c, pixel, exp);
        else passes++;
      end
      tick();
    end
    de_in    = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_mid_cell_drop();
    do_reset();
    tmem[0] = {8'h1F, 8'h10};
    tmem[1] = {8'h1F, 8'h10};
    fmem[12'h100] = 8'hFF;
    fmem[12'h101] = 8'h80;
    de_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) de_in = 1'b0;
      @(negedge clk);
      if (c == 14 || c == 15) begin
        checks++;
        if (pixel !== (c == 14)) $display("FAIL drop_pixel c=%0d got %b want %b", c, pixel, c == 14);
        else passes++;
      end
      tick();
    end
    de_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) de_in = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (text_addr !== 11'd0) $display("FAIL drop_restart_addr got %0d want 0", text_addr);
        else passes++;
      end
      if (c == 2) begin
        checks++;
        if (font_addr !== 12'h101) $display("FAIL drop_restart_font got %h want 101", font_addr);
        else passes++;
      end
      if (c == 3) begin
        checks++;
        if (pixel !== 1'b1) $display("FAIL drop_restart_pixel got %b want 1", pixel);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_blink();
    logic exp;
    do_reset();
    blink_en = 1'b1;
    tmem[0] = {8'h87, 8'h20};
    fmem[12'h200] = 8'hFF;
    for (int f = 0; f < 32; f++) begin
      exp = (f >= 16);
      de_in = 1'b1;
      for (int c = 0; c < 11; c++) begin
        if (c == 8) de_in = 1'b0;
        @(negedge clk);
        if (c == 3) begin
          checks++;
          if (pixel !== exp) $display("FAIL blink_pixel f=%0d got %b want %b", f, pixel, exp);
          else passes++;
          checks++;
          if (attribute !== 8'h07) $display("FAIL blink_attr f=%0d got %h want 07", f, attribute);
          else passes++;
        end
        tick();
      end
      vsync_pulse();
    end
    blink_en = 1'b0;
    #1;
    checks++;
    if (attribute !== 8'h87) $display("FAIL blink_off_attr got %h want 87", attribute);
    else passes++;
  endtask

  task automatic test_cursor();
    logic exp;
    do_reset();
    cursor_col = 7'd2;
    cursor_row = 5'd3;
    cursor_en  = 1'b1;
    for (int i = 240; i <= 242; i++) tmem[i] = {8'h00, 8'h30};
    fmem[12'h30E] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) vsync_pulse();
      skip_lines(62);
      de_in = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if (c == 24) de_in = 1'b0;
        @(negedge clk);
        if (c >= 3 && c <= 26) begin
          exp = (p == 0) && (((c - 3) / 8) == 2);
          checks++;
          if (pixel !== exp)
            $display("FAIL cursor_pixel pass=%0d c=%0d got %b want %b", p, c, pixel, exp);
          else passes++;
        end
        tick();
      end
    end
    cursor_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    de_in      = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    blink_en   = 1'b0;
    cursor_en  = 1'b0;
    cursor_col = 7'd0;
    cursor_row = 5'd0;
    for (int i = 0; i < 2048; i++) tmem[i] = 16'h0000;
    for (int i = 0; i < 4096; i++) fmem[i] = 8'h00;

    test_reset();
    test_cell_pixels();
    test_addressing();
    test_back_to_back();
    test_mid_cell_drop();
    test_blink();
    test_cursor();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
